// File: rtl/riscv_pkg.sv
// Shared types for the branch-predictor update path.
package riscv_pkg;

    localparam int XLEN = 32;

    // One resolved-branch record as queued for the predictor.
    typedef struct packed {
        logic [XLEN-1:0] pc_branch;
        logic [XLEN-1:0] pc_target;
        logic            mispred;
    } pred_upd_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_DISABLED = 2'd2
    } pred_sched_state_e;

endpackage

// File: rtl/pred_upd_fifo.sv
// Record FIFO for pred_upd_sched: storage, wrapping pointers, occupancy.
// The head entry is read combinationally from registered storage.
module pred_upd_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  pred_upd_t                  wdata,
    input  logic                       pop,
    output pred_upd_t                  rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    pred_upd_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage write; clear takes priority so a clearing cycle never leaves data behind.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally on the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pred_upd_sched.sv
// Predictor update scheduler: queues resolved branches and replays them one
// per cycle onto the predictor update port, deferring during fetch lookups,
// discarding on flush/disable and counting the discarded records.
module pred_upd_sched
    import riscv_pkg::*;
#(
    parameter int UPD_DEPTH  = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bu_upd_v_i,
    output logic                  bu_upd_ready_o,
    input  logic [XLEN-1:0]       bu_pc_branch_i,
    input  logic [XLEN-1:0]       bu_pc_target_i,
    input  logic                  bu_mispred_i,
    input  logic                  fetch_lookup_i,
    input  logic                  flush_i,
    input  logic                  pred_ctrl_en_i,
    output logic                  pred_en_o,
    output logic [XLEN-1:0]       pred_pc_branch_o,
    output logic [XLEN-1:0]       pred_pc_target_o,
    output logic                  pred_success_o,
    output logic                  pred_failed_o,
    output logic [DROP_CNT_W-1:0] upd_drop_cnt_o,
    output logic                  upd_busy_o
);

    localparam int CW = $clog2(UPD_DEPTH+1);
    localparam int IW = CW + 1;
    localparam int SW = DROP_CNT_W + IW;

    pred_sched_state_e state, state_next;
    pred_upd_t         head, wrec;
    logic              full, empty, accept, fifo_push, fifo_clr;
    logic [CW-1:0]     count;
    logic [IW-1:0]     drop_inc;
    logic [SW-1:0]     drop_sum;
    logic [DROP_CNT_W-1:0] drop_cnt;

    // Readiness depends only on registered occupancy and flush, never on a same-cycle pop.
    assign bu_upd_ready_o = ~full & ~flush_i;
    assign accept         = bu_upd_v_i & bu_upd_ready_o;
    // Records only enter the FIFO while enabled; otherwise they are counted as dropped.
    assign fifo_push      = accept & pred_ctrl_en_i & (state != ST_DISABLED);
    assign fifo_clr       = flush_i | (~pred_ctrl_en_i & (state != ST_DISABLED));
    assign wrec           = '{pc_branch: bu_pc_branch_i, pc_target: bu_pc_target_i,
                              mispred: bu_mispred_i};

    pred_upd_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .wdata (wrec),
        .pop   (pred_en_o),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state: flush beats disable, disable beats push/pop.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (flush_i)              state_next = ST_IDLE;
                else if (!pred_ctrl_en_i) state_next = ST_DISABLED;
                else if (fifo_push)       state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (flush_i)              state_next = ST_IDLE;
                else if (!pred_ctrl_en_i) state_next = ST_DISABLED;
                else if (pred_en_o && count == CW'(1) && !fifo_push)
                                          state_next = ST_IDLE;
            end
            ST_DISABLED: begin
                if (pred_ctrl_en_i)       state_next = ST_IDLE;
            end
            default:                      state_next = ST_IDLE;
        endcase
    end

    // Issue gating and head-record outputs; data is zeroed when not strobing.
    always_comb begin
        pred_en_o        = (state == ST_ISSUE) & ~fetch_lookup_i & ~flush_i;
        pred_pc_branch_o = pred_en_o ? head.pc_branch : '0;
        pred_pc_target_o = pred_en_o ? head.pc_target : '0;
        pred_success_o   = pred_en_o & ~head.mispred;
        pred_failed_o    = pred_en_o &  head.mispred;
        upd_busy_o       = ~empty;
    end

    // Records lost this cycle: queued ones on flush/disable (minus any popped), plus refused-by-disable pushes.
    always_comb begin
        drop_inc = '0;
        if (state == ST_DISABLED)  drop_inc = IW'(accept);
        else if (flush_i)          drop_inc = IW'(count);
        else if (!pred_ctrl_en_i)  drop_inc = IW'(count) - IW'(pred_en_o) + IW'(accept);
        drop_sum = SW'(drop_cnt) + SW'(drop_inc);
    end

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)                              drop_cnt <= '0;
        else if (drop_sum[SW-1:DROP_CNT_W] != '0) drop_cnt <= '1;
        else                                    drop_cnt <= drop_sum[DROP_CNT_W-1:0];
    end

    assign upd_drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_pred_upd_sched.sv
// Randomized + directed bench for pred_upd_sched against a queue-based model.
module tb_pred_upd_sched;
    import riscv_pkg::*;

    localparam int D    = 4;
    localparam int DW   = 8;
    localparam int DMAX = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            bu_upd_v_i = 1'b0;
    logic            bu_upd_ready_o;
    logic [XLEN-1:0] bu_pc_branch_i = '0;
    logic [XLEN-1:0] bu_pc_target_i = '0;
    logic            bu_mispred_i = 1'b0;
    logic            fetch_lookup_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            pred_ctrl_en_i = 1'b1;
    logic            pred_en_o;
    logic [XLEN-1:0] pred_pc_branch_o;
    logic [XLEN-1:0] pred_pc_target_o;
    logic            pred_success_o;
    logic            pred_failed_o;
    logic [DW-1:0]   upd_drop_cnt_o;
    logic            upd_busy_o;

    pred_upd_sched #(.UPD_DEPTH(D), .DROP_CNT_W(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .bu_upd_v_i       (bu_upd_v_i),
        .bu_upd_ready_o   (bu_upd_ready_o),
        .bu_pc_branch_i   (bu_pc_branch_i),
        .bu_pc_target_i   (bu_pc_target_i),
        .bu_mispred_i     (bu_mispred_i),
        .fetch_lookup_i   (fetch_lookup_i),
        .flush_i          (flush_i),
        .pred_ctrl_en_i   (pred_ctrl_en_i),
        .pred_en_o        (pred_en_o),
        .pred_pc_branch_o (pred_pc_branch_o),
        .pred_pc_target_o (pred_pc_target_o),
        .pred_success_o   (pred_success_o),
        .pred_failed_o    (pred_failed_o),
        .upd_drop_cnt_o   (upd_drop_cnt_o),
        .upd_busy_o       (upd_busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of records, a drop tally and a disabled flag.
    pred_upd_t m_q[$];
    int        m_drop = 0;
    bit        m_dis  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_q.size() < D) && !flush_i;
    endfunction

    function automatic bit m_pen();
        return !m_dis && (m_q.size() > 0) && !fetch_lookup_i && !flush_i;
    endfunction

    // Check outputs mid-cycle, then advance the model across the clock edge.
    task automatic tick();
        bit        rdy, pen, acc;
        pred_upd_t h;
        #4;
        rdy = m_ready();
        pen = m_pen();
        acc = bu_upd_v_i && rdy;
        h   = (m_q.size() > 0) ? m_q[0] : '0;
        chk("ready",   64'(bu_upd_ready_o),   64'(rdy));
        chk("pred_en", 64'(pred_en_o),        64'(pen));
        chk("pc_br",   64'(pred_pc_branch_o), pen ? 64'(h.pc_branch) : 64'd0);
        chk("pc_tgt",  64'(pred_pc_target_o), pen ? 64'(h.pc_target) : 64'd0);
        chk("success", 64'(pred_success_o),   64'(pen && !h.mispred));
        chk("failed",  64'(pred_failed_o),    64'(pen && h.mispred));
        chk("drop",    64'(upd_drop_cnt_o),   64'(m_drop));
        chk("busy",    64'(upd_busy_o),       64'(m_q.size() > 0));
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_drop = 0;
            m_dis  = 1'b0;
        end else if (m_dis) begin
            if (acc) m_drop++;
            m_dis = !pred_ctrl_en_i;
        end else if (flush_i) begin
            m_drop += m_q.size();
            m_q.delete();
        end else if (!pred_ctrl_en_i) begin
            m_drop += m_q.size() - int'(pen) + int'(acc);
            m_q.delete();
            m_dis = 1'b1;
        end else begin
            if (pen) void'(m_q.pop_front());
            if (acc) m_q.push_back('{pc_branch: bu_pc_branch_i,
                                     pc_target: bu_pc_target_i,
                                     mispred:   bu_mispred_i});
        end
        if (m_drop > DMAX) m_drop = DMAX;
        #1;
    endtask

    task automatic drv(input bit v, input bit look, input bit fl, input bit en);
        bu_upd_v_i     = v;
        bu_pc_branch_i = $urandom;
        bu_pc_target_i = $urandom;
        bu_mispred_i   = 1'($urandom);
        fetch_lookup_i = look;
        flush_i        = fl;
        pred_ctrl_en_i = en;
    endtask

    task automatic idle(input int n, input bit look);
        for (int i = 0; i < n; i++) begin
            drv(0, look, 0, 1);
            tick();
        end
    endtask

    // Present one record and hold it until accepted; bounded wait.
    task automatic push_hold(input bit look);
        bit acc = 1'b0;
        drv(1, look, 0, 1);
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = m_ready();
            tick();
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got 0 want 1");
        end
        bu_upd_v_i = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        tick();                       // reset cycle: model clears too
        reset = 1'b0;
        idle(3, 0);                   // reset-state outputs

        // Single push 0x100 -> 0x200, correctly predicted.
        drv(1, 0, 0, 1);
        bu_pc_branch_i = 32'h100;
        bu_pc_target_i = 32'h200;
        bu_mispred_i   = 1'b0;
        tick();
        idle(3, 0);

        // Five pushes under lookup: fifth held until a slot frees.
        for (int i = 0; i < 4; i++) push_hold(1);
        drv(1, 1, 0, 1);
        tick();
        tick();
        push_hold(0);
        idle(6, 0);

        // Flush with three queued and a concurrent push.
        for (int i = 0; i < 3; i++) push_hold(1);
        drv(1, 1, 1, 1);
        tick();
        idle(2, 0);

        // Full FIFO, lookup toggling.
        for (int i = 0; i < 4; i++) push_hold(1);
        for (int i = 0; i < 8; i++) idle(1, (i % 2) == 0);

        // Disable with two queued, then 300 pushes to saturate the counter.
        for (int i = 0; i < 2; i++) push_hold(1);
        drv(0, 1, 0, 0);
        tick();
        for (int i = 0; i < 300; i++) begin
            drv(1, 1'($urandom), 0, 0);
            tick();
        end
        drv(0, 0, 0, 1);
        tick();
        push_hold(0);
        idle(3, 0);

        // Reset mid-drain.
        for (int i = 0; i < 3; i++) push_hold(1);
        idle(1, 0);
        drv(0, 0, 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(2, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            drv(($urandom % 3) != 0, ($urandom % 3) == 0, ($urandom % 25) == 0,
                ($urandom % 40) != 0);
            reset = (($urandom % 500) == 0);
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pred_upd_sched.md
# pred_upd_sched

Update scheduler for the branch predictor table. Buffers resolved-branch records from the branch unit in a small FIFO and replays them one per cycle onto the predictor's single update port. Defers updates while fetch is performing a lookup, discards queued records on pipeline flush, and counts discarded records. Sits between the branch unit (execute stage) and the predictor.

## Interface
- UPD_DEPTH, 4: FIFO entries; power of two, ≥2
- DROP_CNT_W, 8: width of the saturating drop counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset; synchronous, active-high
- bu_upd_v_i  in  1  branch unit presents a resolved branch
- bu_upd_ready_o  out  1  scheduler accepts the record this cycle
- bu_pc_branch_i  in  XLEN  PC of the resolved branch
- bu_pc_target_i  in  XLEN  resolved target
- bu_mispred_i  in  1  1 = prediction was wrong, 0 = correct
- fetch_lookup_i  in  1  fetch is reading the predictor; blocks issue
- flush_i  in  1  pipeline flush; discards all queued records
- pred_ctrl_en_i  in  1  predictor enabled (CSR)
- pred_en_o  out  1  update strobe to predictor
- pred_pc_branch_o  out  XLEN  branch PC to predictor
- pred_pc_target_o  out  XLEN  target to predictor
- pred_success_o  out  1  head record was correctly predicted
- pred_failed_o  out  1  head record was mispredicted
- upd_drop_cnt_o  out  DROP_CNT_W  records discarded by flush/disable, saturating
- upd_busy_o  out  1  FIFO non-empty

## Operation
- Push: `bu_upd_v_i & bu_upd_ready_o` writes {pc_branch, pc_target, mispred} at write pointer. `bu_upd_ready_o = ~full & ~flush_i`; depends only on registered occupancy, never on a same-cycle pop.
- Issue: `pred_en_o = (state==ISSUE) & ~fetch_lookup_i & ~flush_i`. Head record drives outputs combinationally from registered storage; pop happens on the cycle `pred_en_o`=1.
- `pred_success_o = pred_en_o & ~mispred`; `pred_failed_o = pred_en_o & mispred`; never both high. Data outputs are 0 when `pred_en_o`=0.
- Pointers: log2(UPD_DEPTH) bits, wrap naturally; occupancy counter 0..UPD_DEPTH, full at UPD_DEPTH, empty at 0.
- FSM states:
  - IDLE: empty. push → ISSUE. pred_ctrl_en_i=0 → DISABLED.
  - ISSUE: non-empty. Pop leaving zero, no push → IDLE. flush_i → IDLE. pred_ctrl_en_i=0 → DISABLED.
  - DISABLED: FIFO held empty; `bu_upd_ready_o`=1 and pushed records are discarded and counted. pred_ctrl_en_i=1 → IDLE.
- Flush: clears pointers and occupancy next edge; drop counter += occupancy. Push in the flush cycle is refused (ready=0). Flush wins over push, pop and disable.
- Entering DISABLED from ISSUE: remaining occupancy added to drop counter, FIFO cleared.
- Drop counter saturates at 2^DROP_CNT_W−1; cleared only by reset.

## Timing
- Reset: state IDLE, pointers/occupancy 0, drop counter 0; all outputs 0 except `bu_upd_ready_o`=1.
- Push at cycle N → earliest `pred_en_o` at N+1 (no bypass).
- Throughput: one issue per cycle when fetch_lookup_i=0; simultaneous push and pop leaves occupancy unchanged.
- fetch_lookup_i held for k cycles delays issue by exactly k cycles; head record stable during hold.
- FIFO order strictly preserved.
- Reset asserted mid-operation discards all records without counting them.

## Structure
- Record typedef `pred_upd_t` {pc_branch, pc_target, mispred} and state enum `pred_sched_state_e` go in riscv_pkg alongside XLEN.
- One sub-module: `pred_upd_fifo` (storage, pointers, occupancy, full/empty); FSM, issue gating and drop counter stay in the top.

## Test plan
- Single push pc=0x100, target=0x200, mispred=0 at cycle 5 → pred_en_o and success_o high at cycle 6 only, outputs 0x100/0x200; busy_o low at cycle 7.
- Push 5 records back-to-back with fetch_lookup_i=1 (UPD_DEPTH=4) → ready_o low after 4th, 5th held; release lookup → 5 issues in order over 5 consecutive cycles, ready back high after first pop.
- Queue 3 records, assert flush_i with concurrent push → ready_o=0 that cycle, FIFO empty next cycle, upd_drop_cnt_o=3, no pred_en_o.
- Full FIFO with fetch_lookup_i toggling 1,0,1,0 → issues only in the 0 cycles, mispred records raise failed_o not success_o.
- pred_ctrl_en_i=0 with 2 queued, then 300 pushes (DROP_CNT_W=8) → counter saturates at 255, pred_en_o never high; re-enable → IDLE, next push issues normally.
- Reset mid-drain with 3 queued → next cycle all outputs at reset values, drop counter 0.
